// File: rtl/eth_tx_seq.sv
// eth_tx_seq: MAC init, TX buffer fill, length and kick register sequencing.
// Optional `ETH_TX_PAD_EN pads frames shorter than 60 bytes with zero words.
module eth_tx_seq #(
    parameter int          AW             = 32,
    parameter int          MAX_BYTES      = 1536,
    parameter logic [31:0] KICK_VAL       = 32'h8,
    parameter int          TIMEOUT_CYCLES = 8192
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [47:0]   mac_addr_i,
    input  logic [7:0]    cfg_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [63:0]   s_data_i,
    input  logic [7:0]    s_keep_i,
    input  logic          s_last_i,
    output logic          reg_req_o,
    input  logic          reg_gnt_i,
    output logic [AW-1:0] reg_addr_o,
    output logic [63:0]   reg_wdata_o,
    output logic [7:0]    reg_be_o,
    input  logic          tx_done_i,
    output logic          busy_o,
    output logic [15:0]   frame_cnt_o,
    output logic          err_o
);

    localparam int WORDS = MAX_BYTES / 8;
    localparam int WW    = $clog2(WORDS + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [3:0] S_INIT_LO = 4'd0;
    localparam logic [3:0] S_INIT_HI = 4'd1;
    localparam logic [3:0] S_IDLE    = 4'd2;
    localparam logic [3:0] S_DATA    = 4'd3;
    localparam logic [3:0] S_DROP    = 4'd4;
    localparam logic [3:0] S_LEN     = 4'd5;
    localparam logic [3:0] S_KICK    = 4'd6;
    localparam logic [3:0] S_WAIT    = 4'd7;
`ifdef ETH_TX_PAD_EN
    localparam logic [3:0] S_PAD     = 4'd8;
`endif

    logic [3:0]    state;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic [7:0]    be_q;
    logic [WW-1:0] widx;
    logic [11:0]   bc;
    logic          last_q;
    logic [TW-1:0] tmo;
    logic [15:0]   cnt;
    logic          err_q;

    logic [WW-1:0] cur_widx;
    logic [11:0]   cur_bc;
    logic [11:0]   len_val;
    logic [AW-1:0] wr_addr;
    logic          full;
    logic          accept;
`ifdef ETH_TX_PAD_EN
    logic          pad_go;
`endif

    // A new beat may be taken in the same cycle the previous beat is granted.
    assign s_ready_o = (state == S_IDLE) || (state == S_DROP) ||
                       ((state == S_DATA) && (!req_q || (reg_gnt_i && !last_q)));
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        cur_widx = (state == S_IDLE) ? '0 : widx;
        cur_bc   = (state == S_IDLE) ? '0 : bc;
        full     = (32'(cur_widx) == 32'(WORDS));
        wr_addr  = AW'(32'h1000 + (32'(cur_widx) << 3));
        len_val  = bc;
`ifdef ETH_TX_PAD_EN
        pad_go   = (bc < 12'd60) && (32'(widx) < 32'd8);
        if (bc < 12'd60) len_val = 12'd60;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= S_INIT_LO;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            widx    <= '0;
            bc      <= '0;
            last_q  <= 1'b0;
            tmo     <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                S_INIT_LO: begin
                    if (!req_q) begin
                        req_q   <= 1'b1;
                        addr_q  <= AW'(32'h800);
                        wdata_q <= {32'b0, mac_addr_i[31:0]};
                        be_q    <= 8'h0F;
                    end else if (reg_gnt_i) begin
                        state   <= S_INIT_HI;
                        addr_q  <= AW'(32'h808);
                        wdata_q <= {32'b0, 8'b0, cfg_i, mac_addr_i[47:32]};
                    end
                end
                S_INIT_HI: begin
                    if (reg_gnt_i) begin
                        req_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_IDLE, S_DATA: begin
                    if (state == S_DATA && req_q && reg_gnt_i) begin
                        if (last_q) begin
`ifdef ETH_TX_PAD_EN
                            if (pad_go) begin
                                state   <= S_PAD;
                                addr_q  <= wr_addr;
                                wdata_q <= '0;
                                be_q    <= 8'hFF;
                                widx    <= widx + WW'(1);
                            end else begin
                                state   <= S_LEN;
                                addr_q  <= AW'(32'h810);
                                wdata_q <= {52'b0, len_val};
                                be_q    <= 8'h0F;
                            end
`else
                            state   <= S_LEN;
                            addr_q  <= AW'(32'h810);
                            wdata_q <= {52'b0, len_val};
                            be_q    <= 8'h0F;
`endif
                        end else begin
                            req_q <= 1'b0;
                        end
                    end
                    if (accept) begin
                        if (full) begin
                            // Buffer already full: drop the rest of the frame.
                            err_q <= 1'b1;
                            req_q <= 1'b0;
                            state <= s_last_i ? S_IDLE : S_DROP;
                        end else begin
                            req_q   <= 1'b1;
                            addr_q  <= wr_addr;
                            wdata_q <= s_data_i;
                            be_q    <= s_keep_i;
                            widx    <= cur_widx + WW'(1);
                            bc      <= cur_bc + 12'($countones(s_keep_i));
                            last_q  <= s_last_i;
                            state   <= S_DATA;
                        end
                    end
                end
`ifdef ETH_TX_PAD_EN
                S_PAD: begin
                    if (reg_gnt_i) begin
                        if (pad_go) begin
                            addr_q <= wr_addr;
                            widx   <= widx + WW'(1);
                        end else begin
                            state   <= S_LEN;
                            addr_q  <= AW'(32'h810);
                            wdata_q <= {52'b0, len_val};
                            be_q    <= 8'h0F;
                        end
                    end
                end
`endif
                S_DROP: begin
                    if (accept && s_last_i) state <= S_IDLE;
                end
                S_LEN: begin
                    if (reg_gnt_i) begin
                        state   <= S_KICK;
                        addr_q  <= AW'(32'h828);
                        wdata_q <= {32'b0, KICK_VAL};
                        be_q    <= 8'h0F;
                    end
                end
                S_KICK: begin
                    if (reg_gnt_i) begin
                        req_q <= 1'b0;
                        cnt   <= cnt + 16'd1;
                        tmo   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        state <= S_IDLE;
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: begin
                    state <= S_INIT_LO;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign reg_req_o   = req_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_be_o    = be_q;
    assign busy_o      = (state != S_IDLE);
    assign frame_cnt_o = cnt;
    assign err_o       = err_q;

endmodule
